// File: rtl/prefetcher_pkg.sv
// Shared types and constants for the prefetcher opcode scheduler.
// Defines the data-path opcode encoding, the arbiter grant set and the error-code values.
package prefetcher_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PREF    = 3'd1,
    OP_MASTER  = 3'd2,
    OP_SLAVE   = 3'd3,
    OP_PROMISE = 3'd4
  } opcode_e;

  typedef enum logic [2:0] {
    G_NONE,
    G_RIN,
    G_ROUT,
    G_MAR,
    G_PF
  } grant_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_PROMISE   = 3'd3;
  localparam logic [7:0] ERR_CNT_MAX   = 8'hFF;

  function automatic opcode_e grant_to_opcode(input grant_e g);
    case (g)
      G_RIN:   return OP_SLAVE;
      G_ROUT:  return OP_PROMISE;
      G_MAR:   return OP_MASTER;
      G_PF:    return OP_PREF;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/prefetcher_r_outbuf.sv
// One-entry valid/ready holding register for the master R channel.
// o_free tells the scheduler a new beat can be loaded this cycle.
module prefetcher_r_outbuf #(
  parameter int DATA_BITS = 512
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 i_load,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_last,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_last,
  output logic                 o_free
);

  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/prefetcher_op_sched.sv
// Opcode scheduler feeding the single request slot of the prefetcher data path.
// Arbitrates slave R-in, promised R-out, master AR and prefetch requests; owns the slave AR register.
module prefetcher_op_sched
  import prefetcher_pkg::*;
#(
  parameter  int ADDR_BITS            = 64,
  parameter  int LOG_BLOCK_DATA_BYTES = 6,
  parameter  int BURST_LEN_WIDTH      = 8,
  parameter  int STARVE_LIMIT         = 4,
  localparam int DATA_BITS            = 8 << LOG_BLOCK_DATA_BYTES
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [BURST_LEN_WIDTH-1:0] crs_burstLen,
  input  logic                       m_ar_valid,
  input  logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic                       m_ar_ready,
  input  logic                       pf_valid,
  input  logic [ADDR_BITS-1:0]       pf_addr,
  output logic                       pf_ready,
  output logic                       s_ar_valid,
  output logic [ADDR_BITS-1:0]       s_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic                       s_ar_ready,
  input  logic                       s_r_valid,
  input  logic [DATA_BITS-1:0]       s_r_data,
  input  logic                       s_r_last,
  output logic                       s_r_ready,
  output logic                       m_r_valid,
  output logic [DATA_BITS-1:0]       m_r_data,
  output logic                       m_r_last,
  input  logic                       m_r_ready,
  output logic [2:0]                 dp_reqOpcode,
  output logic [ADDR_BITS-1:0]       dp_reqAddr,
  output logic [DATA_BITS-1:0]       dp_reqData,
  output logic                       dp_reqLast,
  input  logic                       dp_addrHit,
  input  logic                       dp_pr_r_valid,
  input  logic                       dp_almostFull,
  input  logic [DATA_BITS-1:0]       dp_respData,
  input  logic                       dp_respLast,
  input  logic [2:0]                 dp_errorCode,
  output logic [2:0]                 err_sticky,
  output logic [7:0]                 err_cnt
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                       r_toggle;
  logic [STARVE_W-1:0]        r_starve_cnt;
  logic                       r_s_ar_valid;
  logic [ADDR_BITS-1:0]       r_s_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] r_s_ar_len;
  logic [2:0]                 r_err_sticky;
  logic [7:0]                 r_err_cnt;

  logic   w_rin, w_rout, w_mar, w_pf, w_ar_req, w_starved, w_ar_granted;
  logic   w_sar_free, w_outbuf_free, w_sar_load;
  grant_e w_grant;

  assign w_sar_free = !r_s_ar_valid || s_ar_ready;
  assign w_rin      = s_r_valid;
  assign w_rout     = dp_pr_r_valid && w_outbuf_free;
  assign w_mar      = m_ar_valid && (dp_addrHit || w_sar_free);
  assign w_pf       = pf_valid && !m_ar_valid && !dp_almostFull && w_sar_free;
  assign w_ar_req   = w_mar || w_pf;
  assign w_starved  = (r_starve_cnt == STARVE_MAX);

  // Address mux is independent of the grant so dp_addrHit settles within the cycle.
  assign dp_reqAddr = m_ar_valid ? m_ar_addr : pf_addr;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_grant = G_NONE;
    if (!resetN) begin
      w_grant = G_NONE;
    end else if (w_ar_req && (w_starved || !(w_rin || w_rout))) begin
      w_grant = w_mar ? G_MAR : G_PF;
    end else if (w_rin && w_rout) begin
      w_grant = r_toggle ? G_ROUT : G_RIN;
    end else if (w_rin) begin
      w_grant = G_RIN;
    end else if (w_rout) begin
      w_grant = G_ROUT;
    end
  end

  assign w_ar_granted = (w_grant == G_MAR) || (w_grant == G_PF);
  assign w_sar_load   = (w_grant == G_PF) || ((w_grant == G_MAR) && !dp_addrHit);

  always_comb begin
    dp_reqOpcode = grant_to_opcode(w_grant);
    dp_reqData   = '0;
    dp_reqLast   = 1'b0;
    s_r_ready    = (w_grant == G_RIN);
    m_ar_ready   = (w_grant == G_MAR);
    pf_ready     = (w_grant == G_PF);
    if (w_grant == G_RIN) begin
      dp_reqData = s_r_data;
      dp_reqLast = s_r_last;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_toggle     <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      if (w_rin && w_rout && (w_grant == G_RIN || w_grant == G_ROUT))
        r_toggle <= !r_toggle;
      if (!w_ar_req || w_ar_granted)
        r_starve_cnt <= '0;
      else if (!w_starved)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // A new load may land in the same cycle the slave accepts the previous request.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s_ar_valid <= 1'b0;
      r_s_ar_addr  <= '0;
      r_s_ar_len   <= '0;
    end else if (w_sar_load) begin
      r_s_ar_valid <= 1'b1;
      r_s_ar_addr  <= dp_reqAddr;
      r_s_ar_len   <= crs_burstLen - BURST_LEN_WIDTH'(1);
    end else if (s_ar_ready) begin
      r_s_ar_valid <= 1'b0;
    end
  end

  assign s_ar_valid = r_s_ar_valid;
  assign s_ar_addr  = r_s_ar_addr;
  assign s_ar_len   = r_s_ar_len;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_err_sticky <= ERR_NONE;
      r_err_cnt    <= '0;
    end else if (dp_errorCode != ERR_NONE) begin
      if (r_err_sticky == ERR_NONE)
        r_err_sticky <= dp_errorCode;
      if (r_err_cnt != ERR_CNT_MAX)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;

  prefetcher_r_outbuf #(
    .DATA_BITS (DATA_BITS)
  ) u_r_outbuf (
    .clk     (clk),
    .resetN  (resetN),
    .i_load  (w_grant == G_ROUT),
    .i_data  (dp_respData),
    .i_last  (dp_respLast),
    .i_ready (m_r_ready),
    .o_valid (m_r_valid),
    .o_data  (m_r_data),
    .o_last  (m_r_last),
    .o_free  (w_outbuf_free)
  );

endmodule

// File: tb/tb_prefetcher_op_sched.sv
// Directed bench for prefetcher_op_sched: one task per scenario with hand-computed expectations.
module tb_prefetcher_op_sched;

  localparam int ADDR_BITS = 64;
  localparam int DATA_BITS = 512;
  localparam int BLW       = 8;

  logic                 clk = 1'b0;
  logic                 resetN;
  logic [BLW-1:0]       crs_burstLen;
  logic                 m_ar_valid, m_ar_ready, pf_valid, pf_ready;
  logic [ADDR_BITS-1:0] m_ar_addr, pf_addr, s_ar_addr, dp_reqAddr;
  logic                 s_ar_valid, s_ar_ready;
  logic [BLW-1:0]       s_ar_len;
  logic                 s_r_valid, s_r_last, s_r_ready;
  logic [DATA_BITS-1:0] s_r_data, m_r_data, dp_reqData, dp_respData;
  logic                 m_r_valid, m_r_last, m_r_ready;
  logic [2:0]           dp_reqOpcode, dp_errorCode, err_sticky;
  logic                 dp_reqLast, dp_addrHit, dp_pr_r_valid, dp_almostFull, dp_respLast;
  logic [7:0]           err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefetcher_op_sched dut (
    .clk(clk), .resetN(resetN), .crs_burstLen(crs_burstLen),
    .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_ready(m_ar_ready),
    .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_last(s_r_last), .s_r_ready(s_r_ready),
    .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_ready(m_r_ready),
    .dp_reqOpcode(dp_reqOpcode), .dp_reqAddr(dp_reqAddr), .dp_reqData(dp_reqData), .dp_reqLast(dp_reqLast),
    .dp_addrHit(dp_addrHit), .dp_pr_r_valid(dp_pr_r_valid), .dp_almostFull(dp_almostFull),
    .dp_respData(dp_respData), .dp_respLast(dp_respLast), .dp_errorCode(dp_errorCode),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_ar_valid = 1'b0; m_ar_addr = '0; pf_valid = 1'b0; pf_addr = '0;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0; s_r_last = 1'b0;
    m_r_ready = 1'b0; dp_addrHit = 1'b0; dp_pr_r_valid = 1'b0; dp_almostFull = 1'b0;
    dp_respData = '0; dp_respLast = 1'b0; dp_errorCode = 3'd0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    crs_burstLen = 8'd4;
    idle_inputs();
    #3;
    checks++; if (dp_reqOpcode !== 3'd0) begin errors++; $display("FAIL reset_opcode got %0d exp 0", dp_reqOpcode); end
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_s_ar_valid got %b exp 0", s_ar_valid); end
    checks++; if (m_r_valid !== 1'b0) begin errors++; $display("FAIL reset_m_r_valid got %b exp 0", m_r_valid); end
    checks++; if (err_cnt !== 8'd0 || err_sticky !== 3'd0) begin errors++; $display("FAIL reset_err got cnt %0d sticky %0d exp 0 0", err_cnt, err_sticky); end
    cyc(); cyc();
    resetN = 1'b1;
    cyc();
  endtask

  task automatic test_master_miss();
    m_ar_valid = 1'b1; m_ar_addr = 64'h1000; dp_addrHit = 1'b0; #1;
    checks++; if (dp_reqOpcode !== 3'd2) begin errors++; $display("FAIL miss_opcode got %0d exp 2", dp_reqOpcode); end
    checks++; if (m_ar_ready !== 1'b1) begin errors++; $display("FAIL miss_m_ar_ready got %b exp 1", m_ar_ready); end
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL miss_s_ar_early got %b exp 0", s_ar_valid); end
    cyc();
    m_ar_valid = 1'b0; #1;
    checks++; if (s_ar_valid !== 1'b1 || s_ar_addr !== 64'h1000) begin errors++; $display("FAIL miss_s_ar got v %b addr %h exp 1 1000", s_ar_valid, s_ar_addr); end
    checks++; if (s_ar_len !== 8'd3) begin errors++; $display("FAIL miss_s_ar_len got %0d exp 3", s_ar_len); end
    checks++; if (m_ar_ready !== 1'b0 || dp_reqOpcode !== 3'd0) begin errors++; $display("FAIL miss_after got rdy %b op %0d exp 0 0", m_ar_ready, dp_reqOpcode); end
    s_ar_ready = 1'b1;
    cyc();
    s_ar_ready = 1'b0; #1;
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL miss_s_ar_clear got %b exp 0", s_ar_valid); end
  endtask

  task automatic test_prefetch_hit();
    pf_valid = 1'b1; pf_addr = 64'h2000; #1;
    checks++; if (dp_reqOpcode !== 3'd1 || pf_ready !== 1'b1) begin errors++; $display("FAIL pf_grant got op %0d rdy %b exp 1 1", dp_reqOpcode, pf_ready); end
    cyc();
    pf_valid = 1'b0; #1;
    checks++; if (s_ar_valid !== 1'b1 || s_ar_addr !== 64'h2000 || s_ar_len !== 8'd3) begin errors++; $display("FAIL pf_s_ar got v %b addr %h len %0d exp 1 2000 3", s_ar_valid, s_ar_addr, s_ar_len); end
    s_ar_ready = 1'b1; m_ar_valid = 1'b1; m_ar_addr = 64'h2000; dp_addrHit = 1'b1; #1;
    checks++; if (dp_reqOpcode !== 3'd2 || m_ar_ready !== 1'b1) begin errors++; $display("FAIL hit_grant got op %0d rdy %b exp 2 1", dp_reqOpcode, m_ar_ready); end
    cyc();
    m_ar_valid = 1'b0; dp_addrHit = 1'b0; s_ar_ready = 1'b0; #1;
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL hit_no_s_ar got %b exp 0", s_ar_valid); end
  endtask

  task automatic test_alternate();
    logic [2:0] exp_op;
    logic       exp_mv;
    for (int i = 0; i < 8; i++) begin
      s_r_valid = 1'b1; s_r_data = DATA_BITS'(32'h50 + i); s_r_last = 1'b0;
      dp_pr_r_valid = 1'b1; m_r_ready = 1'b1;
      dp_respData = DATA_BITS'(32'hA0 + i); dp_respLast = (i == 5);
      #1;
      exp_op = (i % 2 == 1) ? 3'd4 : 3'd3;
      exp_mv = (i > 0) && (i % 2 == 0);
      checks++; if (dp_reqOpcode !== exp_op) begin errors++; $display("FAIL alt_opcode[%0d] got %0d exp %0d", i, dp_reqOpcode, exp_op); end
      checks++; if (m_r_valid !== exp_mv) begin errors++; $display("FAIL alt_m_r_valid[%0d] got %b exp %b", i, m_r_valid, exp_mv); end
      if (exp_mv) begin
        checks++; if (m_r_data !== DATA_BITS'(32'hA0 + i - 1) || m_r_last !== (i == 6)) begin errors++; $display("FAIL alt_m_r_data[%0d] got %h last %b", i, m_r_data[31:0], m_r_last); end
      end
      if (exp_op == 3'd3) begin
        checks++; if (dp_reqData !== DATA_BITS'(32'h50 + i) || s_r_ready !== 1'b1) begin errors++; $display("FAIL alt_rin[%0d] got data %h rdy %b", i, dp_reqData[31:0], s_r_ready); end
      end
      cyc();
    end
    s_r_valid = 1'b0; dp_pr_r_valid = 1'b0; #1;
    checks++; if (m_r_valid !== 1'b1 || m_r_data !== DATA_BITS'(32'hA7)) begin errors++; $display("FAIL alt_tail got v %b data %h exp 1 a7", m_r_valid, m_r_data[31:0]); end
    cyc();
    checks++; if (m_r_valid !== 1'b0) begin errors++; $display("FAIL alt_drain got %b exp 0", m_r_valid); end
    m_r_ready = 1'b0;
  endtask

  task automatic test_starvation();
    int  losses = 0;
    logic granted = 1'b0;
    s_r_valid = 1'b1; dp_pr_r_valid = 1'b1; m_r_ready = 1'b1;
    m_ar_valid = 1'b1; m_ar_addr = 64'h3000; dp_addrHit = 1'b1;
    for (int k = 0; k < 10 && !granted; k++) begin
      #1;
      if (m_ar_ready === 1'b1) begin
        granted = 1'b1;
        checks++; if (dp_reqOpcode !== 3'd2) begin errors++; $display("FAIL starve_grant_op got %0d exp 2", dp_reqOpcode); end
      end else begin
        losses++;
        checks++; if (dp_reqOpcode !== ((k % 2 == 1) ? 3'd4 : 3'd3)) begin errors++; $display("FAIL starve_lose_op[%0d] got %0d", k, dp_reqOpcode); end
        cyc();
      end
    end
    checks++; if (!granted || losses != 4) begin errors++; $display("FAIL starve_count got granted %b losses %0d exp 1 4", granted, losses); end
    cyc();
    m_ar_valid = 1'b0; dp_addrHit = 1'b0; #1;
    checks++; if (dp_reqOpcode !== 3'd3) begin errors++; $display("FAIL starve_resume got %0d exp 3", dp_reqOpcode); end
    cyc();
    s_r_valid = 1'b0; dp_pr_r_valid = 1'b0;
    cyc(); cyc();
    m_r_ready = 1'b0;
  endtask

  task automatic test_sar_backpressure();
    pf_valid = 1'b1; pf_addr = 64'h4000; #1;
    checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL bp_pf got %b exp 1", pf_ready); end
    cyc();
    pf_valid = 1'b0; m_ar_valid = 1'b1; m_ar_addr = 64'h5000; dp_addrHit = 1'b0; #1;
    checks++; if (dp_reqOpcode !== 3'd0 || m_ar_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked got op %0d rdy %b exp 0 0", dp_reqOpcode, m_ar_ready); end
    cyc();
    checks++; if (dp_reqOpcode !== 3'd0 || s_ar_valid !== 1'b1 || s_ar_addr !== 64'h4000) begin errors++; $display("FAIL bp_hold got op %0d v %b addr %h", dp_reqOpcode, s_ar_valid, s_ar_addr); end
    s_ar_ready = 1'b1; #1;
    checks++; if (dp_reqOpcode !== 3'd2 || m_ar_ready !== 1'b1) begin errors++; $display("FAIL bp_release got op %0d rdy %b exp 2 1", dp_reqOpcode, m_ar_ready); end
    cyc();
    m_ar_valid = 1'b0; s_ar_ready = 1'b0; #1;
    checks++; if (s_ar_valid !== 1'b1 || s_ar_addr !== 64'h5000) begin errors++; $display("FAIL bp_b2b got v %b addr %h exp 1 5000", s_ar_valid, s_ar_addr); end
    s_ar_ready = 1'b1;
    cyc();
    s_ar_ready = 1'b0;
  endtask

  task automatic test_almost_full_err_reset();
    dp_almostFull = 1'b1; pf_valid = 1'b1; pf_addr = 64'h6000; #1;
    checks++; if (pf_ready !== 1'b0 || dp_reqOpcode !== 3'd0) begin errors++; $display("FAIL af_pf got rdy %b op %0d exp 0 0", pf_ready, dp_reqOpcode); end
    cyc();
    checks++; if (pf_ready !== 1'b0 || s_ar_valid !== 1'b0) begin errors++; $display("FAIL af_pf_hold got rdy %b sar %b exp 0 0", pf_ready, s_ar_valid); end
    m_ar_valid = 1'b1; m_ar_addr = 64'h7000; dp_addrHit = 1'b0; #1;
    checks++; if (dp_reqOpcode !== 3'd2 || dp_reqAddr !== 64'h7000) begin errors++; $display("FAIL af_miss got op %0d addr %h exp 2 7000", dp_reqOpcode, dp_reqAddr); end
    cyc();
    m_ar_valid = 1'b0; pf_valid = 1'b0; dp_almostFull = 1'b0; s_ar_ready = 1'b1; #1;
    checks++; if (s_ar_valid !== 1'b1 || s_ar_addr !== 64'h7000) begin errors++; $display("FAIL af_s_ar got v %b addr %h exp 1 7000", s_ar_valid, s_ar_addr); end
    cyc();
    s_ar_ready = 1'b0;
    dp_errorCode = 3'd2; cyc();
    dp_errorCode = 3'd3; cyc();
    dp_errorCode = 3'd0; cyc();
    checks++; if (err_sticky !== 3'd2 || err_cnt !== 8'd2) begin errors++; $display("FAIL err got sticky %0d cnt %0d exp 2 2", err_sticky, err_cnt); end
    s_r_valid = 1'b1; dp_pr_r_valid = 1'b1; m_ar_valid = 1'b1; m_ar_addr = 64'h8000;
    cyc(); cyc();
    resetN = 1'b0; #1;
    checks++; if (dp_reqOpcode !== 3'd0 || s_r_ready !== 1'b0 || m_ar_ready !== 1'b0 || pf_ready !== 1'b0) begin errors++; $display("FAIL rst_comb got op %0d srr %b mar %b pfr %b", dp_reqOpcode, s_r_ready, m_ar_ready, pf_ready); end
    checks++; if (m_r_valid !== 1'b0 || s_ar_valid !== 1'b0 || err_sticky !== 3'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_regs got mrv %b sar %b sticky %0d cnt %0d", m_r_valid, s_ar_valid, err_sticky, err_cnt); end
    idle_inputs();
    cyc();
    resetN = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_master_miss();
    test_prefetch_hit();
    test_alternate();
    test_starvation();
    test_sar_backpressure();
    test_almost_full_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
